// File: rtl/midi_decoder.sv
// midi_decoder: MIDI 8N1 serial receiver and channel-voice message parser.
// Optional feature macro: MIDI_RUNNING_STATUS_EN (retain running status).
`timescale 1ns/1ps
module midi_decoder #(
    parameter int CLKS_PER_BIT = 3200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       msg_valid,
    output logic [1:0] msg_type,
    output logic [3:0] channel,
    output logic [6:0] data1,
    output logic [6:0] data2,
    output logic       framing_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] TYPE_NOTE_OFF = 2'd0;
    localparam logic [1:0] TYPE_NOTE_ON  = 2'd1;
    localparam logic [1:0] TYPE_PROGRAM  = 2'd2;

    typedef enum logic [2:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP,
        U_BREAK
    } uart_state_e;

    typedef enum logic [1:0] {
        P_WAIT_STATUS,
        P_WAIT_D1,
        P_WAIT_D2
    } parse_state_e;

    // Synchronizer
    logic rx_meta_q;
    logic rx_sync_q;

    // UART receiver
    uart_state_e      u_state_q, u_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_stb;
    logic [7:0]       rx_byte;

    // Parser
    parse_state_e p_state_q, p_state_d;
    logic [7:0]   status_q, status_d;
    logic         len2_q, len2_d;
    logic [6:0]   d1_q, d1_d;

    // Byte classes and completion helpers
    logic       is_rt;
    logic       is_sys;
    logic       is_chan;
    logic       is_data;
    logic       done;
    logic [6:0] cmp_d1;
    logic [6:0] cmp_d2;

    // Registered outputs
    logic       msg_valid_q, msg_valid_d;
    logic [1:0] msg_type_q, msg_type_d;
    logic [3:0] channel_q, channel_d;
    logic [6:0] data1_q, data1_d;
    logic [6:0] data2_q, data2_d;
    logic       framing_err_q, framing_err_d;

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // UART next state: half-bit start check, then one sample per bit period.
    always_comb begin
        u_state_d     = u_state_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        byte_stb      = 1'b0;
        framing_err_d = 1'b0;
        unique case (u_state_q)
            U_IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) begin
                    u_state_d = U_START;
                end
            end
            U_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_d     = '0;
                    u_state_d = rx_sync_q ? U_IDLE : U_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            U_DATA: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        u_state_d = U_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            U_STOP: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_stb  = 1'b1;
                        u_state_d = U_IDLE;
                    end else begin
                        framing_err_d = 1'b1;
                        u_state_d     = U_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            U_BREAK: begin
                cnt_d = '0;
                if (rx_sync_q) begin
                    u_state_d = U_IDLE;
                end
            end
            default: begin
                u_state_d = U_IDLE;
            end
        endcase
    end

    // UART state, counters and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            u_state_q <= U_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            u_state_q <= u_state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    assign rx_byte = shift_q;

    // Classify the received byte; the four classes are mutually exclusive.
    always_comb begin
        is_rt   = &rx_byte[7:3];
        is_sys  = (rx_byte[7:4] == 4'hF) && !rx_byte[3];
        is_chan = rx_byte[7] && (rx_byte[7:4] != 4'hF);
        is_data = !rx_byte[7];
    end

    // Parser next state and message assembly on each received byte.
    always_comb begin
        p_state_d   = p_state_q;
        status_d    = status_q;
        len2_d      = len2_q;
        d1_d        = d1_q;
        done        = 1'b0;
        cmp_d1      = '0;
        cmp_d2      = '0;
        msg_valid_d = 1'b0;
        msg_type_d  = msg_type_q;
        channel_d   = channel_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        if (byte_stb) begin
            unique case (1'b1)
                is_rt: begin
                end
                is_sys: begin
                    p_state_d = P_WAIT_STATUS;
                    status_d  = '0;
                    len2_d    = 1'b0;
                end
                is_chan: begin
                    p_state_d = P_WAIT_D1;
                    status_d  = rx_byte;
                    len2_d    = (rx_byte[7:4] != 4'hC) &&
                                (rx_byte[7:4] != 4'hD);
                end
                is_data: begin
                    unique case (p_state_q)
                        P_WAIT_STATUS: begin
                        end
                        P_WAIT_D1: begin
                            if (len2_q) begin
                                d1_d      = rx_byte[6:0];
                                p_state_d = P_WAIT_D2;
                            end else begin
                                done   = 1'b1;
                                cmp_d1 = rx_byte[6:0];
                            end
                        end
                        P_WAIT_D2: begin
                            done   = 1'b1;
                            cmp_d1 = d1_q;
                            cmp_d2 = rx_byte[6:0];
                        end
                        default: begin
                            p_state_d = P_WAIT_STATUS;
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
        if (done) begin
            unique case (status_q[7:4])
                4'h8: begin
                    msg_valid_d = 1'b1;
                    msg_type_d  = TYPE_NOTE_OFF;
                    data2_d     = cmp_d2;
                end
                4'h9: begin
                    msg_valid_d = 1'b1;
                    msg_type_d  = (cmp_d2 != 7'd0) ? TYPE_NOTE_ON
                                                   : TYPE_NOTE_OFF;
                    data2_d     = cmp_d2;
                end
                4'hC: begin
                    msg_valid_d = 1'b1;
                    msg_type_d  = TYPE_PROGRAM;
                    data2_d     = '0;
                end
                default: begin
                end
            endcase
            if (msg_valid_d) begin
                channel_d = status_q[3:0];
                data1_d   = cmp_d1;
            end
`ifdef MIDI_RUNNING_STATUS_EN
            p_state_d = P_WAIT_D1;
`else
            p_state_d = P_WAIT_STATUS;
            status_d  = '0;
            len2_d    = 1'b0;
`endif
        end
    end

    // Parser state and running status.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_state_q <= P_WAIT_STATUS;
            status_q  <= '0;
            len2_q    <= 1'b0;
            d1_q      <= '0;
        end else begin
            p_state_q <= p_state_d;
            status_q  <= status_d;
            len2_q    <= len2_d;
            d1_q      <= d1_d;
        end
    end

    // Output fields load only with a message; strobes last one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_valid_q   <= 1'b0;
            msg_type_q    <= '0;
            channel_q     <= '0;
            data1_q       <= '0;
            data2_q       <= '0;
            framing_err_q <= 1'b0;
        end else begin
            msg_valid_q   <= msg_valid_d;
            msg_type_q    <= msg_type_d;
            channel_q     <= channel_d;
            data1_q       <= data1_d;
            data2_q       <= data2_d;
            framing_err_q <= framing_err_d;
        end
    end

    assign msg_valid   = msg_valid_q;
    assign msg_type    = msg_type_q;
    assign channel     = channel_q;
    assign data1       = data1_q;
    assign data2       = data2_q;
    assign framing_err = framing_err_q;

endmodule

// File: tb/tb_midi_decoder.sv
// tb_midi_decoder: serial-line stimulus for midi_decoder with a
// byte-stream reference model of the MIDI message rules.
`timescale 1ns/1ps
module tb_midi_decoder;

    localparam int CPB = 16;
    localparam int LAT = (CPB * 19) / 2 + 3;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        int t;
        int ch;
        int d1;
        int d2;
        int at;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       msg_valid;
    logic [1:0] msg_type;
    logic [3:0] channel;
    logic [6:0] data1;
    logic [6:0] data2;
    logic       framing_err;

    midi_decoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .msg_valid  (msg_valid),
        .msg_type   (msg_type),
        .channel    (channel),
        .data1      (data1),
        .data2      (data2),
        .framing_err(framing_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t     got[$];
    ev_t     exp_q[$];
    int      ferr_at[$];
    int      n_cmp = 0;
    int      n_bad = 0;
    int      m_status = 0;
    int      m_data[$];
    int      last_fall = 0;
    int      exp_ferr = 0;
    byte_q_t bq;
    int      nib[8] = '{8, 9, 9, 12, 10, 11, 13, 14};

    // Record every strobe seen on the outputs.
    always @(negedge clk) begin
        ev_t e;
        if (msg_valid) begin
            e.t  = int'(msg_type);
            e.ch = int'(channel);
            e.d1 = int'(data1);
            e.d2 = int'(data2);
            e.at = cyc;
            got.push_back(e);
        end
        if (framing_err) ferr_at.push_back(cyc);
    end

    function automatic int need_len(input int s);
        return ((s / 16) == 12 || (s / 16) == 13) ? 1 : 2;
    endfunction

    // Reference model: applies one received byte to the message rules.
    task automatic model_byte(input int b);
        ev_t e;
        if (b >= 'hF8) return;
        if (b >= 'hF0) begin
            m_status = 0;
            m_data.delete();
            return;
        end
        if (b >= 'h80) begin
            m_status = b;
            m_data.delete();
            return;
        end
        if (m_status == 0) return;
        m_data.push_back(b);
        if (m_data.size() < need_len(m_status)) return;
        e.ch = m_status % 16;
        e.d1 = m_data[0];
        e.d2 = (m_data.size() == 2) ? m_data[1] : 0;
        e.at = last_fall + LAT;
        case (m_status / 16)
            8:  begin e.t = 0; exp_q.push_back(e); end
            9:  begin e.t = (e.d2 != 0) ? 1 : 0; exp_q.push_back(e); end
            12: begin e.t = 2; e.d2 = 0; exp_q.push_back(e); end
            default: ;
        endcase
        m_data.delete();
`ifndef MIDI_RUNNING_STATUS_EN
        m_status = 0;
`endif
    endtask

    // Drive one 8N1 frame; call and return at a rising edge.
    task automatic send_byte(input logic [7:0] b, input bit bad_stop,
                             input int idle);
        #1 rx = 1'b0;
        last_fall = cyc;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        if (bad_stop) begin
            #1 rx = 1'b0;
            repeat (3 * CPB) @(posedge clk);
        end
        #1 rx = 1'b1;
        repeat (CPB) @(posedge clk);
        repeat (idle) @(posedge clk);
        if (bad_stop) exp_ferr++;
        else model_byte(int'(b));
    endtask

    task automatic send_list(input byte_q_t bs, input int idle);
        foreach (bs[i]) send_byte(bs[i], 1'b0, idle);
        repeat (2) @(posedge clk);
    endtask

    task automatic clear_obs();
        got.delete();
        exp_q.delete();
        ferr_at.delete();
        exp_ferr = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({msg_valid, msg_type, channel, data1, data2, framing_err}
            !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b t=%0d ch=%0d d1=%h d2=%h fe=%b want all 0",
                     msg_valid, msg_type, channel, data1, data2, framing_err);
        end
        rst = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_note_on();
        clear_obs();
        bq = '{8'h93, 8'h3C, 8'h64};
        send_list(bq, 5);
        n_cmp++;
        if (got.size() != 1) begin
            n_bad++;
            $display("FAIL note_on_count: got %0d want 1", got.size());
        end else begin
            n_cmp++;
            if (got[0].t != 1 || got[0].ch != 3 || got[0].d1 != 'h3C ||
                got[0].d2 != 'h64) begin
                n_bad++;
                $display("FAIL note_on_fields: got t=%0d ch=%0d d1=%h d2=%h want 1 3 3c 64",
                         got[0].t, got[0].ch, got[0].d1, got[0].d2);
            end
            n_cmp++;
            if (got[0].at != last_fall + LAT) begin
                n_bad++;
                $display("FAIL note_on_timing: got cycle %0d want %0d",
                         got[0].at, last_fall + LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        bq = '{8'h90, 8'h40, 8'h00, 8'hC5, 8'h0A};
        send_list(bq, 0);
        n_cmp++;
        if (got.size() != 2) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d want 2", got.size());
        end else begin
            n_cmp++;
            if (got[0].t != 0 || got[0].ch != 0 || got[0].d1 != 'h40 ||
                got[0].d2 != 0) begin
                n_bad++;
                $display("FAIL b2b_note_off: got t=%0d ch=%0d d1=%h d2=%h want 0 0 40 0",
                         got[0].t, got[0].ch, got[0].d1, got[0].d2);
            end
            n_cmp++;
            if (got[1].t != 2 || got[1].ch != 5 || got[1].d1 != 'h0A ||
                got[1].d2 != 0) begin
                n_bad++;
                $display("FAIL b2b_program: got t=%0d ch=%0d d1=%h d2=%h want 2 5 0a 0",
                         got[1].t, got[1].ch, got[1].d1, got[1].d2);
            end
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (i < exp_q.size() && got[i].at != exp_q[i].at) begin
                    n_bad++;
                    $display("FAIL b2b_timing[%0d]: got cycle %0d want %0d",
                             i, got[i].at, exp_q[i].at);
                end
            end
        end
    endtask

    task automatic test_running_status();
        int want;
`ifdef MIDI_RUNNING_STATUS_EN
        want = 2;
`else
        want = 1;
`endif
        clear_obs();
        bq = '{8'h91, 8'h3C, 8'h7F, 8'h3E, 8'h7F};
        send_list(bq, 3);
        n_cmp++;
        if (got.size() != want) begin
            n_bad++;
            $display("FAIL running_count: got %0d want %0d", got.size(), want);
        end else begin
            for (int i = 0; i < want; i++) begin
                n_cmp++;
                if (got[i].t != 1 || got[i].ch != 1 ||
                    got[i].d1 != 'h3C + 2 * i || got[i].d2 != 'h7F) begin
                    n_bad++;
                    $display("FAIL running_fields[%0d]: got t=%0d ch=%0d d1=%h d2=%h want 1 1 %h 7f",
                             i, got[i].t, got[i].ch, got[i].d1, got[i].d2,
                             'h3C + 2 * i);
                end
            end
        end
    endtask

    task automatic test_realtime();
        clear_obs();
        bq = '{8'h92, 8'h30, 8'hF8, 8'h50};
        send_list(bq, 0);
        n_cmp++;
        if (got.size() != 1) begin
            n_bad++;
            $display("FAIL realtime_count: got %0d want 1", got.size());
        end else begin
            n_cmp++;
            if (got[0].t != 1 || got[0].ch != 2 || got[0].d1 != 'h30 ||
                got[0].d2 != 'h50) begin
                n_bad++;
                $display("FAIL realtime_fields: got t=%0d ch=%0d d1=%h d2=%h want 1 2 30 50",
                         got[0].t, got[0].ch, got[0].d1, got[0].d2);
            end
        end
        got.delete();
        bq = '{8'hB0, 8'h07, 8'h40};
        send_list(bq, 2);
        n_cmp++;
        if (got.size() != 0) begin
            n_bad++;
            $display("FAIL control_silent: got %0d strobes want 0", got.size());
        end
        n_cmp++;
        if (msg_type !== 2'd1 || channel !== 4'd2 || data1 !== 7'h30 ||
            data2 !== 7'h50) begin
            n_bad++;
            $display("FAIL fields_hold: got t=%0d ch=%0d d1=%h d2=%h want 1 2 30 50",
                     msg_type, channel, data1, data2);
        end
    endtask

    task automatic test_framing();
        clear_obs();
        send_byte(8'h90, 1'b1, CPB);
        n_cmp++;
        if (ferr_at.size() != 1) begin
            n_bad++;
            $display("FAIL framing_count: got %0d want 1", ferr_at.size());
        end else begin
            n_cmp++;
            if (ferr_at[0] != last_fall + LAT) begin
                n_bad++;
                $display("FAIL framing_timing: got cycle %0d want %0d",
                         ferr_at[0], last_fall + LAT);
            end
        end
        n_cmp++;
        if (got.size() != 0) begin
            n_bad++;
            $display("FAIL framing_no_msg: got %0d strobes want 0", got.size());
        end
        bq = '{8'h80, 8'h3C, 8'h00};
        send_list(bq, 1);
        n_cmp++;
        if (got.size() != 1 || got[0].t != 0 || got[0].ch != 0 ||
            got[0].d1 != 'h3C || got[0].d2 != 0) begin
            n_bad++;
            $display("FAIL framing_recover: got %0d strobes, first d1=%h want 1 note off 3c",
                     got.size(), (got.size() > 0) ? got[0].d1 : -1);
        end
    endtask

    task automatic test_glitch();
        clear_obs();
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        n_cmp++;
        if (got.size() != 0 || ferr_at.size() != 0) begin
            n_bad++;
            $display("FAIL glitch: got %0d strobes %0d framing want 0 0",
                     got.size(), ferr_at.size());
        end
    endtask

    task automatic test_midmsg_reset();
        logic [7:0] b;
        clear_obs();
        b = 8'h3C;
        send_byte(8'h90, 1'b0, 0);
        #1 rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rst = 1'b1;
        rx = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_status = 0;
        m_data.delete();
        n_cmp++;
        if ({msg_valid, msg_type, channel, data1, data2, framing_err}
            !== 22'd0) begin
            n_bad++;
            $display("FAIL midmsg_reset_outputs: got v=%b t=%0d ch=%0d d1=%h d2=%h fe=%b want all 0",
                     msg_valid, msg_type, channel, data1, data2, framing_err);
        end
        @(posedge clk);
        repeat (12 * CPB) @(posedge clk);
        n_cmp++;
        if (got.size() != 0 || ferr_at.size() != 0) begin
            n_bad++;
            $display("FAIL midmsg_reset_quiet: got %0d strobes %0d framing want 0 0",
                     got.size(), ferr_at.size());
        end
        bq = '{8'h90, 8'h3C, 8'h64};
        send_list(bq, 0);
        n_cmp++;
        if (got.size() != 1 || got[0].t != 1 || got[0].ch != 0 ||
            got[0].d1 != 'h3C || got[0].d2 != 'h64) begin
            n_bad++;
            $display("FAIL midmsg_reset_recover: got %0d strobes, first d1=%h want 1 note on 3c 64",
                     got.size(), (got.size() > 0) ? got[0].d1 : -1);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         r;
        int         idle;
        int         n;
        bit         bad;
        clear_obs();
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 99);
            if (r < 25)
                b = {4'(nib[$urandom_range(0, 7)]), 4'($urandom_range(0, 15))};
            else if (r < 31)
                b = 8'hF8 + 8'($urandom_range(0, 7));
            else if (r < 34)
                b = 8'hF0 + 8'($urandom_range(0, 7));
            else if ($urandom_range(0, 5) == 0)
                b = 8'h00;
            else
                b = 8'($urandom_range(0, 127));
            idle = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
            bad  = ($urandom_range(0, 29) == 0);
            send_byte(b, bad, idle);
        end
        repeat (4) @(posedge clk);
        n_cmp++;
        if (got.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL random_count: got %0d want %0d",
                     got.size(), exp_q.size());
        end
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (got[i].t != exp_q[i].t || got[i].ch != exp_q[i].ch ||
                got[i].d1 != exp_q[i].d1 || got[i].d2 != exp_q[i].d2 ||
                got[i].at != exp_q[i].at) begin
                n_bad++;
                $display("FAIL random_msg[%0d]: got t=%0d ch=%0d d1=%h d2=%h @%0d want t=%0d ch=%0d d1=%h d2=%h @%0d",
                         i, got[i].t, got[i].ch, got[i].d1, got[i].d2,
                         got[i].at, exp_q[i].t, exp_q[i].ch, exp_q[i].d1,
                         exp_q[i].d2, exp_q[i].at);
            end
        end
        n_cmp++;
        if (ferr_at.size() != exp_ferr) begin
            n_bad++;
            $display("FAIL random_framing: got %0d want %0d",
                     ferr_at.size(), exp_ferr);
        end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_back_to_back();
        test_running_status();
        test_realtime();
        test_framing();
        test_glitch();
        test_midmsg_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
